// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// Two-stage pipelined ALU (8 ops, C/Z/N/V flags, internal accumulator).
// Latency: beat accepted on edge N is presented with out_valid after edge N+1.
// Backpressure: valid/ready both sides; stage 1 drains into stage 2 whenever it is free, no bubbles.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_wr,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_acc_sel_q, s1_acc_sel_d;
    logic             s1_acc_wr_q, s1_acc_wr_d;
    logic [WIDTH-1:0] s1_i0_q, s1_i0_d;
    logic [WIDTH-1:0] s1_i1_q, s1_i1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] op_a, op_b, alu_o;
    logic [WIDTH:0]   alu_w, shr_w;
    logic [SHW-1:0]   sh;
    logic             alu_c, alu_v;
    logic             adv, accept;

    // Operand A reads the live accumulator, so a dependent beat right behind a writer sees its result.
    always_comb begin
        op_a  = s1_acc_sel_q ? acc_q : s1_i0_q;
        op_b  = s1_i1_q;
        sh    = op_b[SHW-1:0];
        alu_w = '0;
        shr_w = '0;
        alu_v = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                alu_w = {1'b0, op_a} + {1'b0, op_b};
                alu_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_w = {1'b0, op_a} + {1'b0, ~op_b} + ONE;
                alu_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_w = {1'b0, op_a & op_b};
            OP_OR:  alu_w = {1'b0, op_a | op_b};
            OP_XOR: alu_w = {1'b0, op_a ^ op_b};
            OP_SHL: alu_w = {1'b0, op_a} << sh;
            OP_SHR: begin
                // Extra LSB catches the last bit shifted out; stays 0 for a zero shift.
                shr_w = {op_a, 1'b0} >> sh;
                alu_w = {shr_w[0], shr_w[WIDTH:1]};
            end
            default: alu_w = {1'b0, op_b};
        endcase
        alu_o = alu_w[WIDTH-1:0];
        alu_c = alu_w[WIDTH];
    end

    always_comb begin
        adv      = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = reset && (!s1_valid_q || adv);
        accept   = in_valid && in_ready;

        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_acc_sel_d = s1_acc_sel_q;
        s1_acc_wr_d  = s1_acc_wr_q;
        s1_i0_d      = s1_i0_q;
        s1_i1_d      = s1_i1_q;
        out_valid_d  = out_valid_q;
        o_d          = o_q;
        cout_d       = cout_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        acc_d        = acc_q;

        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_op_d      = op;
            s1_acc_sel_d = acc_sel;
            s1_acc_wr_d  = acc_wr;
            s1_i0_d      = i0;
            s1_i1_d      = i1;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end

        if (adv) begin
            out_valid_d = 1'b1;
            o_d         = alu_o;
            cout_d      = alu_c;
            zero_d      = (alu_o == '0);
            neg_d       = alu_o[WIDTH-1];
            ovf_d       = alu_v;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear takes priority over a write landing on the same edge.
        if (acc_clr) begin
            acc_d = '0;
        end else if (adv && s1_acc_wr_q) begin
            acc_d = alu_o;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_acc_sel_q <= 1'b0;
            s1_acc_wr_q  <= 1'b0;
            s1_i0_q      <= '0;
            s1_i1_q      <= '0;
            out_valid_q  <= 1'b0;
            o_q          <= '0;
            cout_q       <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_acc_sel_q <= s1_acc_sel_d;
            s1_acc_wr_q  <= s1_acc_wr_d;
            s1_i0_q      <= s1_i0_d;
            s1_i1_q      <= s1_i1_d;
            out_valid_q  <= out_valid_d;
            o_q          <= o_d;
            cout_q       <= cout_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
// Bench for alu_pipe (WIDTH=16): directed vector table, handshake/accumulator/reset sequences,
// and a randomized stream checked against an arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        acc_sel = 1'b0;
    logic        acc_wr = 1'b0;
    logic        acc_clr = 1'b0;
    logic [15:0] i0 = '0;
    logic [15:0] i1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] o;
    logic        cout, zero, neg, ovf;
    logic [15:0] acc;

    alu_pipe #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_sel(acc_sel), .acc_wr(acc_wr), .acc_clr(acc_clr),
        .i0(i0), .i1(i1), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] o; logic c; logic z; logic n; logic v;} res_t;
    typedef struct packed {logic [2:0] op; logic asel; logic awr; logic [15:0] i0; logic [15:0] i1;} beat_t;
    typedef struct packed {beat_t b; res_t e;} vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    beat_t       send_q[$];
    res_t        exp_q[$];
    logic [15:0] model_acc = '0;
    bit          saw_full = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic res_t cur_res();
        return {o, cout, zero, neg, ovf};
    endfunction

    // Reference: plain integer arithmetic on unsigned/signed views of the operands.
    function automatic res_t model(input logic [2:0] op_m, input logic [15:0] a, input logic [15:0] b);
        int   ua, ub, sa, sb, s, r;
        res_t m;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = ub % 16;
        r  = 0;
        m  = '0;
        case (op_m)
            3'd0: begin r = ua + ub; m.c = (r > 65535); m.v = (sa + sb > 32767) || (sa + sb < -32768); end
            3'd1: begin r = ua - ub; m.c = (ua >= ub); m.v = (sa - sb > 32767) || (sa - sb < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << s; if (s != 0) m.c = ((ua >> (16 - s)) & 1) != 0; end
            3'd6: begin r = ua >> s; if (s != 0) m.c = ((ua >> (s - 1)) & 1) != 0; end
            default: r = ub;
        endcase
        m.o = r[15:0];
        m.z = (m.o == 16'h0000);
        m.n = m.o[15];
        return m;
    endfunction

    function automatic vec_t mk(input logic [2:0] p, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] eo, input logic c, input logic z, input logic n, input logic v);
        vec_t t;
        t.b = {p, 1'b0, 1'b0, a, b};
        t.e = {eo, c, z, n, v};
        return t;
    endfunction

    task automatic put_beat(input beat_t bt);
        op = bt.op; acc_sel = bt.asel; acc_wr = bt.awr; i0 = bt.i0; i1 = bt.i1;
    endtask

    // Single beat into an empty pipe: checks acceptance, one-edge gap, then result.
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        put_beat(v.b); in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({name, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({name, ".early"}, out_valid, 0);
        @(negedge clk);
        #1 chk({name, ".out_valid"}, out_valid, 1);
        chk(name, cur_res(), v.e);
    endtask

    // rdy_mode: 0 always ready, 1 stall cycles 2..4, 2 random.
    task automatic run_stream(input int n_exp, input int budget, input bit use_model, input int rdy_mode);
        int    got = 0;
        int    cyc = 0;
        bit    stalled = 0;
        bit    taken = 0;
        res_t  prev = '0;
        beat_t bt;
        res_t  r;
        in_valid = 1'b0;
        while (got < n_exp && cyc < budget) begin
            @(negedge clk);
            if (taken) begin in_valid = 1'b0; taken = 0; end
            if (!in_valid && send_q.size() > 0 && (rdy_mode != 2 || $urandom_range(0, 9) < 7)) begin
                put_beat(send_q[0]);
                in_valid = 1'b1;
            end
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = !(cyc >= 2 && cyc <= 4);
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
            #1;
            if (stalled) chk("stall_hold", {out_valid, cur_res()}, {1'b1, prev});
            if (in_valid && !in_ready && out_valid && !out_ready) saw_full = 1;
            if (in_valid && in_ready) begin
                bt = send_q.pop_front();
                taken = 1;
                if (use_model) begin
                    r = model(bt.op, bt.asel ? model_acc : bt.i0, bt.i1);
                    if (bt.awr) model_acc = r.o;
                    exp_q.push_back(r);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL stream_extra: got %h, expected no beat", cur_res());
                end else begin
                    chk("stream", cur_res(), exp_q.pop_front());
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            prev = cur_res();
            cyc++;
        end
        if (got < n_exp) chk("stream_timeout", got, n_exp);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    vec_t  vecs[14];
    beat_t bt;

    initial begin
        vecs[0]  = mk(3'd0, 16'hffff, 16'h0001, 16'h0000, 1, 1, 0, 0);
        vecs[1]  = mk(3'd1, 16'h0001, 16'h7fff, 16'h8002, 0, 0, 1, 0);
        vecs[2]  = mk(3'd0, 16'h7fff, 16'h0001, 16'h8000, 0, 0, 1, 1);
        vecs[3]  = mk(3'd5, 16'h8001, 16'h0001, 16'h0002, 1, 0, 0, 0);
        vecs[4]  = mk(3'd6, 16'h0003, 16'h0000, 16'h0003, 0, 0, 0, 0);
        vecs[5]  = mk(3'd6, 16'h8000, 16'h000f, 16'h0001, 0, 0, 0, 0);
        vecs[6]  = mk(3'd1, 16'h0005, 16'h0005, 16'h0000, 1, 1, 0, 0);
        vecs[7]  = mk(3'd1, 16'h8000, 16'h0001, 16'h7fff, 1, 0, 0, 1);
        vecs[8]  = mk(3'd2, 16'haa55, 16'h55aa, 16'h0000, 0, 1, 0, 0);
        vecs[9]  = mk(3'd3, 16'haa55, 16'h55aa, 16'hffff, 0, 0, 1, 0);
        vecs[10] = mk(3'd4, 16'hf0f0, 16'hff00, 16'h0ff0, 0, 0, 0, 0);
        vecs[11] = mk(3'd7, 16'h1234, 16'habcd, 16'habcd, 0, 0, 1, 0);
        vecs[12] = mk(3'd5, 16'h0001, 16'hffff, 16'h8000, 0, 0, 1, 0);
        vecs[13] = mk(3'd6, 16'h0001, 16'h0001, 16'h0000, 1, 1, 0, 0);

        // Reset state.
        #1 reset = 1'b0;
        #2;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.o", o, 0);
        chk("rst.flags", {cout, zero, neg, ovf}, 0);
        chk("rst.acc", acc, 0);
        chk("rst.in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rel.in_ready", in_ready, 1);

        for (int k = 0; k < 14; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Four-beat stream with a three-cycle sink stall.
        send_q.push_back({3'd2, 1'b0, 1'b0, 16'haa55, 16'h55aa});
        send_q.push_back({3'd3, 1'b0, 1'b0, 16'haa55, 16'h55aa});
        send_q.push_back({3'd4, 1'b0, 1'b0, 16'haa55, 16'h55aa});
        send_q.push_back({3'd7, 1'b0, 1'b0, 16'haa55, 16'h55aa});
        exp_q.push_back({16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({16'hffff, 1'b0, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({16'hffff, 1'b0, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({16'h55aa, 1'b0, 1'b0, 1'b0, 1'b0});
        saw_full = 0;
        run_stream(4, 60, 0, 1);
        chk("stall.in_ready_low", saw_full, 1);
        chk("stall.leftover", exp_q.size(), 0);

        // Accumulator chain.
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        #1 chk("acc_clr", acc, 0);
        for (int k = 0; k < 3; k++) send_q.push_back({3'd0, 1'b1, 1'b1, 16'hdead, 16'h0005});
        exp_q.push_back({16'h0005, 4'b0000});
        exp_q.push_back({16'h000a, 4'b0000});
        exp_q.push_back({16'h000f, 4'b0000});
        run_stream(3, 60, 0, 0);
        chk("acc_chain", acc, 16'h000f);

        // Clear on the same edge as a write: result uses the old value, clear wins.
        @(negedge clk);
        put_beat({3'd0, 1'b1, 1'b1, 16'h0000, 16'h0001});
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        #1 chk("clr_wr.valid", out_valid, 1);
        chk("clr_wr.result", cur_res(), {16'h0010, 4'b0000});
        chk("clr_wr.acc", acc, 0);

        // Randomized stream against the model.
        model_acc = 16'h0000;
        for (int k = 0; k < 300; k++) begin
            bt.op   = 3'($urandom_range(0, 7));
            bt.asel = ($urandom_range(0, 3) == 0);
            bt.awr  = ($urandom_range(0, 3) == 0);
            bt.i0   = 16'($urandom);
            bt.i1   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16)) : 16'($urandom);
            send_q.push_back(bt);
        end
        run_stream(300, 5000, 1, 2);
        chk("rand.acc", acc, model_acc);

        // Reset with two beats in flight.
        @(negedge clk);
        put_beat({3'd7, 1'b0, 1'b1, 16'h0000, 16'h1111});
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        put_beat({3'd7, 1'b0, 1'b0, 16'h0000, 16'h2222});
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("flight.valid", out_valid, 1);
        chk("flight.acc", acc, 16'h1111);
        reset = 1'b0;
        #1 chk("arst.out_valid", out_valid, 0);
        chk("arst.acc", acc, 0);
        chk("arst.o", o, 0);
        chk("arst.in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1 chk($sformatf("no_stale%0d", k), out_valid, 0);
        end
        run_vec(mk(3'd7, 16'h0000, 16'h0042, 16'h0042, 0, 0, 0, 0), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
